// File: rtl/d_input_debouncer.sv
// Synchroniser plus counter-FSM debouncer for the d_flip_flop data input.
// Optional glitch counter is built only when DEBOUNCE_GLITCH_CNT_EN is defined.
module d_input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_LEVEL     = 0,
  parameter int GCNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_in,
  output logic              d_out,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              stable,
  output logic [GCNT_W-1:0] glitch_cnt,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic RL = (RESET_LEVEL != 0);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_out_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   s;

  // Only the last synchroniser stage is ever looked at by the FSM.
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= {SYNC_STAGES{RL}};
      d_out_q <= RL;
      state_q <= RL ? STABLE_HI : STABLE_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= STABLE_HI;
              d_out_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              state_q <= WAIT_HI;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            d_out_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= STABLE_LO;
              d_out_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              state_q <= WAIT_LO;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            d_out_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign d_out      = d_out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign stable     = (state_q == STABLE_LO) || (state_q == STABLE_HI);
  assign dbg_state  = state_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic              glitch_evt;
  logic [GCNT_W-1:0] gcnt_q;

  // An abort is a WAIT state seeing the original level again.
  assign glitch_evt = ((state_q == WAIT_HI) && !s) || ((state_q == WAIT_LO) && s);

  always_ff @(posedge clk) begin
    if (!rst) begin
      gcnt_q <= '0;
    end else if (glitch_evt && (gcnt_q != {GCNT_W{1'b1}})) begin
      gcnt_q <= gcnt_q + 1'b1;
    end
  end

  assign glitch_cnt = gcnt_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_d_input_debouncer.sv
// Directed bench for d_input_debouncer at default parameters; expected values hand-derived.
module tb_d_input_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       raw_in = 1'b0;
  logic       d_out, rise_pulse, fall_pulse, stable;
  logic [7:0] glitch_cnt;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  d_input_debouncer dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .d_out      (d_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .stable     (stable),
    .glitch_cnt (glitch_cnt),
    .dbg_state  (dbg_state)
  );

  // Advance one posedge, then settle 1 time unit away from the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic lvl);
    check({tag, "_dout"}, 32'(d_out), 32'(lvl));
    check({tag, "_stable"}, 32'(stable), 32'd1);
    check({tag, "_rise"}, 32'(rise_pulse), 32'd0);
    check({tag, "_fall"}, 32'(fall_pulse), 32'd0);
  endtask

  int exp_g;

  initial begin
    // 1. reset with raw_in high
    rst = 1'b0;
    raw_in = 1'b1;
    tick(2);
    check_idle("rst", 1'b0);
    check("rst_gcnt", 32'(glitch_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // 2. release reset with raw_in already high: rise on 6th edge
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      check($sformatf("rise_wait_dout_e%0d", e), 32'(d_out), 32'd0);
      check($sformatf("rise_wait_pulse_e%0d", e), 32'(rise_pulse), 32'd0);
      check($sformatf("rise_wait_stable_e%0d", e), 32'(stable), (e >= 3) ? 32'd0 : 32'd1);
    end
    tick(1);
    check("rise_e6_dout", 32'(d_out), 32'd1);
    check("rise_e6_pulse", 32'(rise_pulse), 32'd1);
    check("rise_e6_fall", 32'(fall_pulse), 32'd0);
    check("rise_e6_stable", 32'(stable), 32'd1);
    tick(1);
    check("rise_e7_pulse", 32'(rise_pulse), 32'd0);
    check("rise_e7_dout", 32'(d_out), 32'd1);
    check("rise_e7_state", 32'(dbg_state), 32'd2);

    // 4. fall on 6th edge
    raw_in = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      check($sformatf("fall_wait_dout_e%0d", e), 32'(d_out), 32'd1);
      check($sformatf("fall_wait_pulse_e%0d", e), 32'(fall_pulse), 32'd0);
    end
    tick(1);
    check("fall_e6_dout", 32'(d_out), 32'd0);
    check("fall_e6_pulse", 32'(fall_pulse), 32'd1);
    check("fall_e6_rise", 32'(rise_pulse), 32'd0);
    tick(1);
    check("fall_e7_pulse", 32'(fall_pulse), 32'd0);
    tick(2);

    // 3. raw high for 3 edges: three synced samples, then abort
    raw_in = 1'b1;
    tick(3);
    raw_in = 1'b0;
    for (int e = 4; e <= 8; e++) begin
      tick(1);
      check($sformatf("glitch_dout_e%0d", e), 32'(d_out), 32'd0);
      check($sformatf("glitch_rise_e%0d", e), 32'(rise_pulse), 32'd0);
    end
    check_idle("glitch_end", 1'b0);
    check("glitch_state", 32'(dbg_state), 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_cnt1", 32'(glitch_cnt), 32'd1);
`else
    check("glitch_cnt1", 32'(glitch_cnt), 32'd0);
`endif

    // 5. reset while in WAIT_HI with cnt=2
    raw_in = 1'b1;
    tick(4);
    check("wait_state", 32'(dbg_state), 32'd1);
    check("wait_stable", 32'(stable), 32'd0);
    rst = 1'b0;
    tick(1);
    check_idle("midrst", 1'b0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_gcnt", 32'(glitch_cnt), 32'd0);
    raw_in = 1'b0;
    rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      check($sformatf("postrst_rise_e%0d", e), 32'(rise_pulse), 32'd0);
      check($sformatf("postrst_dout_e%0d", e), 32'(d_out), 32'd0);
    end

    // 6. 260 one-sample glitches: counter saturates when built
    for (int g = 1; g <= 260; g++) begin
      raw_in = 1'b1;
      tick(1);
      raw_in = 1'b0;
      tick(4);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      exp_g = (g > 255) ? 255 : g;
`else
      exp_g = 0;
`endif
      if (g == 1 || g == 254 || g == 255 || g == 256 || g == 260) begin
        check($sformatf("sat_gcnt_g%0d", g), 32'(glitch_cnt), 32'(exp_g));
        check($sformatf("sat_dout_g%0d", g), 32'(d_out), 32'd0);
      end
    end
    check_idle("sat_end", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
